// File: rtl/writeback_unit.sv
// Write-back stage: merges ALU results with queued load responses onto the
// single register-file write port, with WAW suppression and hazard lookup.
module writeback_unit #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [ADDR_WIDTH-1:0]       alu_rd,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    input  logic                        mem_valid,
    output logic                        mem_ready,
    input  logic [ADDR_WIDTH-1:0]       mem_rd,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    output logic                        rf_write_enable,
    output logic [ADDR_WIDTH-1:0]       rf_write_addr,
    output logic [DATA_WIDTH-1:0]       rf_write_data,
    input  logic [ADDR_WIDTH-1:0]       query_addr,
    output logic                        query_hit,
    output logic [$clog2(DEPTH):0]      pending_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] q_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]      q_stale;
    logic [DEPTH-1:0]      q_live;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_writes;

    assign full          = (count == CW'(DEPTH));
    assign mem_ready     = reset && !full;
    assign push          = mem_valid && mem_ready;
    assign pop           = !alu_valid && (count != '0);
    assign pending_count = count;
    assign head_writes   = (q_rd[head] != '0) && !q_stale[head];

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        logic [PW-1:0] offset;
        offset = '0;
        q_live = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset    = PW'(i) - head;
            q_live[i] = ({1'b0, offset} < count);
        end
    end

    always_comb begin
        query_hit = 1'b0;
        if (reset && (query_addr != '0)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (q_live[i] && !q_stale[i] && (q_rd[i] == query_addr))
                    query_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= mem_rd;
            q_data[tail] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            q_stale         <= '0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;

            // The push slot is cleared after marking, so a same-edge load counts as younger.
            if (alu_valid && (alu_rd != '0)) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (q_live[i] && (q_rd[i] == alu_rd))
                        q_stale[i] <= 1'b1;
                end
            end
            if (push)
                q_stale[tail] <= 1'b0;

            if (alu_valid) begin
                rf_write_enable <= (alu_rd != '0);
                if (alu_rd != '0) begin
                    rf_write_addr <= alu_rd;
                    rf_write_data <= alu_data;
                end
            end else if (pop) begin
                rf_write_enable <= head_writes;
                if (head_writes) begin
                    rf_write_addr <= q_rd[head];
                    rf_write_data <= q_data[head];
                end
            end else begin
                rf_write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-back stage for the pipelined CPU and the sole driver of the register file's write port (`write_enable`/`write_addr`/`write_data`). It merges single-cycle ALU results with load responses from the memory stage. Load responses are held in a small queue and drained into cycles the ALU leaves idle. It also exposes a pending-load lookup for decode-stage hazard detection.

## Interface
Parameters:
- DEPTH, 4: load-response queue entries; power of two, >= 2
- DATA_WIDTH, 32: register data width
- ADDR_WIDTH, 5: register index width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  **reset is synchronous and active-low; one clock (`clk`)**
- alu_valid  input  1  ALU result present this cycle; no backpressure
- alu_rd  input  ADDR_WIDTH  ALU destination register
- alu_data  input  DATA_WIDTH  ALU result
- mem_valid  input  1  load response offered
- mem_ready  output  1  queue accepts a load response this cycle
- mem_rd  input  ADDR_WIDTH  load destination register
- mem_data  input  DATA_WIDTH  load data
- rf_write_enable  output  1  register-file write strobe; registered
- rf_write_addr  output  ADDR_WIDTH  register-file write index; registered
- rf_write_data  output  DATA_WIDTH  register-file write data; registered
- query_addr  input  ADDR_WIDTH  decode-stage source register to check
- query_hit  output  1  a live queued load targets query_addr; combinational
- pending_count  output  $clog2(DEPTH)+1  current queue occupancy

## Operation
**Reset** (reset == 0 at a clock edge):
- rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0.
- Queue emptied; pending_count = 0; all stale flags cleared.
- mem_ready = 0 and query_hit = 0 while reset is low.
- Reset during operation discards queued loads; no write is issued for them.

**Enqueue**
- mem_ready = !full, where full means pending_count == DEPTH.
- An entry {rd, data, stale = 0} is pushed when mem_valid && mem_ready.
- When full, no push occurs even if a dequeue happens in the same cycle.

**Write-port selection** (one selection per cycle):
- alu_valid: the ALU result is selected; the queue does not drain.
- !alu_valid and queue non-empty: the head entry is popped and selected.
- Neither: nothing is selected.
- On the next edge, the output register loads the selected addr/data.
- rf_write_enable = 1 only if something was selected, its rd != 0, and it is not a stale entry.
- rd == 0 or stale entries are consumed silently: enable is 0, and addr/data hold their previous values.

**WAW protection**
- When alu_valid && alu_rd != 0, every queued entry with rd == alu_rd is marked stale at that edge.
- This keeps an older load from overwriting a newer ALU result.
- An entry pushed in that same edge is treated as younger and is not marked stale.

**query_hit**
- 1 when query_addr != 0 and some valid, non-stale queue entry has rd == query_addr.

**Occupancy**
- pending_count increments on a push, decrements on a pop, and is unchanged when both occur in the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- ALU path: alu_valid at cycle N gives rf_write_enable at cycle N+1, one cycle wide per result.
- Load path: a push at the edge ending cycle N makes the entry poppable in cycle N+1. With no ALU traffic, rf_write_enable is high in cycle N+2.
- Back-to-back loads with an idle ALU sustain one write per cycle.
- Continuous alu_valid starves the queue indefinitely. Once the queue fills, mem_ready stays 0 until an ALU-idle cycle.
- query_hit reflects state after the most recent edge. It does not include same-cycle pushes, and it does not include the entry already in the output register; the register file's write forwarding covers that entry.
- pending_count and mem_ready update at the edge following a push or pop.

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with mem_valid = 1 and alu_valid = 1. Required: rf_write_enable = 0, pending_count = 0, mem_ready = 0. After release, mem_ready = 1.
- **ALU write:** alu_valid = 1, alu_rd = 1, alu_data = 0x12345678 at cycle N. Required: cycle N+1 has rf_write_enable = 1, addr = 1, data = 0x12345678. Repeat with alu_rd = 0 and data 0xDEADBEEF: rf_write_enable stays 0.
- **Load drain under priority:** push loads (rd 2, 0xABCDEF01) and (rd 3, 0xCAFEBABE) while alu_valid = 1 for 3 cycles, then idle. Required: ALU writes first, then rd 2 and rd 3 in order on consecutive cycles; pending_count goes 2 → 1 → 0.
- **Full queue:** hold alu_valid = 1 and offer 5 loads. Required: 4 accepted, then mem_ready = 0 and pending_count = 4. After ALU idles, all 4 drain in FIFO order and mem_ready returns to 1.
- **WAW stale:** queue a load (rd 5, 0x11111111), then an ALU write (rd 5, 0x22222222) while the load is still queued. Required: only 0x22222222 is written to x5. The load pops with rf_write_enable = 0, and query_hit for addr 5 drops to 0 after the ALU edge.
- **query_hit and wrap:** fill and drain the queue more than DEPTH times with rd = 7..10. Required: query_hit = 1 for addr 7 exactly while that entry is queued. query_addr = 0 gives 0. Data order is preserved across pointer wrap.
